// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC operation codes
// and the return-address-stack count width.
package pc_seq_pkg;

   localparam logic [2:0] OP_SEQ    = 3'd0;
   localparam logic [2:0] OP_BRANCH = 3'd1;
   localparam logic [2:0] OP_JUMP   = 3'd2;
   localparam logic [2:0] OP_CALL   = 3'd3;
   localparam logic [2:0] OP_RET    = 3'd4;

   // ras_count must hold 0..DEPTH inclusive, hence one bit above the pointer width.
   function automatic int unsigned ras_cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pc_adder.sv
// Combinational a + b + cin modulo 2^ADDR_W; the carry-out is intentionally dropped.
module pc_adder #(
   parameter int unsigned ADDR_W = 12
) (
   input  logic [ADDR_W-1:0] a,
   input  logic [ADDR_W-1:0] b,
   input  logic              cin,
   output logic [ADDR_W-1:0] sum
);

   assign sum = a + b + {{(ADDR_W-1){1'b0}}, cin};

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with sequential/branch/jump/call/return selection
// and a circular return-address stack.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 12,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          stall,
   input  logic [2:0]                    op,
   input  logic [ADDR_W-1:0]             offset,
   input  logic [ADDR_W-1:0]             target,
   output logic [ADDR_W-1:0]             pc,
   output logic [ADDR_W-1:0]             pc_plus1,
   output logic [ras_cnt_w(DEPTH)-1:0]   ras_count,
   output logic                          ras_empty,
   output logic                          ras_full,
   output logic                          ras_ovf,
   output logic                          ras_unf
);

   localparam int unsigned CNT_W = ras_cnt_w(DEPTH);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] branch_pc;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] ras_mem [DEPTH];
   logic [PTR_W-1:0]  ras_ptr;
   logic [PTR_W-1:0]  ras_ptr_inc;
   logic              push;
   logic              pop;
   logic              ovf_next;
   logic              unf_next;

   pc_adder #(.ADDR_W(ADDR_W)) u_inc (
      .a   (pc),
      .b   ({ADDR_W{1'b0}}),
      .cin (1'b1),
      .sum (pc_plus1)
   );

   pc_adder #(.ADDR_W(ADDR_W)) u_branch (
      .a   (pc),
      .b   (offset),
      .cin (1'b1),
      .sum (branch_pc)
   );

   assign ras_empty   = (ras_count == '0);
   assign ras_full    = (ras_count == CNT_W'(DEPTH));
   assign ras_ptr_inc = ras_ptr + PTR_W'(1);

   always_comb begin
      pc_next  = pc;
      push     = 1'b0;
      pop      = 1'b0;
      ovf_next = 1'b0;
      unf_next = 1'b0;
      if (!stall) begin
         case (op)
            OP_BRANCH: pc_next = branch_pc;
            OP_JUMP:   pc_next = target;
            OP_CALL: begin
               pc_next  = target;
               push     = 1'b1;
               ovf_next = ras_full;
            end
            OP_RET: begin
               if (ras_empty) begin
                  pc_next  = pc_plus1;
                  unf_next = 1'b1;
               end else begin
                  pc_next = ras_mem[ras_ptr];
                  pop     = 1'b1;
               end
            end
            default:   pc_next = pc_plus1;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc        <= RESET_PC;
         ras_count <= '0;
         ras_ptr   <= '0;
         ras_ovf   <= 1'b0;
         ras_unf   <= 1'b0;
      end else begin
         pc      <= pc_next;
         ras_ovf <= ovf_next;
         ras_unf <= unf_next;
         if (push) begin
            ras_ptr <= ras_ptr_inc;
            if (!ras_full) ras_count <= ras_count + CNT_W'(1);
         end else if (pop) begin
            ras_ptr   <= ras_ptr - PTR_W'(1);
            ras_count <= ras_count - CNT_W'(1);
         end
      end
   end

   // When full, ptr+1 is the oldest slot, so the push overwrites it in place.
   always_ff @(posedge clock) begin
      if (!reset && push) ras_mem[ras_ptr_inc] <= pc_plus1;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer, checked against a queue-based
// model of the return-address stack.
module tb_pc_sequencer;
   import pc_seq_pkg::*;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned MASK   = 32'hFFF;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic [2:0]  op;
   logic [11:0] offset;
   logic [11:0] target;
   logic [11:0] pc;
   logic [11:0] pc_plus1;
   logic [2:0]  ras_count;
   logic        ras_empty;
   logic        ras_full;
   logic        ras_ovf;
   logic        ras_unf;

   int errors = 0;
   int checks = 0;

   int unsigned m_pc;
   int unsigned m_q[$];
   bit          m_ovf;
   bit          m_unf;

   always #5 clock = ~clock;

   pc_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(12'h000)) dut (
      .clock     (clock),
      .reset     (reset),
      .stall     (stall),
      .op        (op),
      .offset    (offset),
      .target    (target),
      .pc        (pc),
      .pc_plus1  (pc_plus1),
      .ras_count (ras_count),
      .ras_empty (ras_empty),
      .ras_full  (ras_full),
      .ras_ovf   (ras_ovf),
      .ras_unf   (ras_unf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance the architectural model by one clock using the rules for each op.
   task automatic model_step(input bit rst, input bit stl, input int unsigned o,
                             input int unsigned off, input int unsigned tgt);
      int signed soff;
      m_ovf = 0;
      m_unf = 0;
      if (rst) begin
         m_pc = 0;
         m_q.delete();
      end else if (!stl) begin
         soff = (off >= 2048) ? int'(off) - 4096 : int'(off);
         case (o)
            1: m_pc = (m_pc + 1 + soff) & MASK;
            2: m_pc = tgt;
            3: begin
               m_q.push_back((m_pc + 1) & MASK);
               if (m_q.size() > DEPTH) begin
                  void'(m_q.pop_front());
                  m_ovf = 1;
               end
               m_pc = tgt;
            end
            4: begin
               if (m_q.size() > 0) m_pc = m_q.pop_back();
               else begin
                  m_pc  = (m_pc + 1) & MASK;
                  m_unf = 1;
               end
            end
            default: m_pc = (m_pc + 1) & MASK;
         endcase
      end
   endtask

   task automatic step(input bit rst, input bit stl, input int unsigned o,
                       input int unsigned off, input int unsigned tgt);
      reset  = rst;
      stall  = stl;
      op     = 3'(o);
      offset = 12'(off);
      target = 12'(tgt);
      @(posedge clock);
      model_step(rst, stl, o, off, tgt);
      #1;
      check("pc", 32'(pc), m_pc);
      check("pc_plus1", 32'(pc_plus1), (m_pc + 1) & MASK);
      check("ras_count", 32'(ras_count), m_q.size());
      check("ras_empty", 32'(ras_empty), 32'(m_q.size() == 0));
      check("ras_full", 32'(ras_full), 32'(m_q.size() == DEPTH));
      check("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
      check("ras_unf", 32'(ras_unf), 32'(m_unf));
   endtask

   initial begin
      m_pc = 0;
      // Reset then sequential run
      step(1, 0, 0, 0, 0);
      check("reset_pc", 32'(pc), 0);
      check("reset_empty", 32'(ras_empty), 1);
      for (int i = 1; i <= 3; i++) begin
         step(0, 0, 0, 0, 0);
         check("seq_pc", 32'(pc), i);
      end
      // Wrap-around and negative branch
      step(0, 0, 2, 0, 'hFFF);
      step(0, 0, 0, 0, 0);
      check("wrap_pc", 32'(pc), 0);
      step(0, 0, 2, 0, 'h010);
      step(0, 0, 1, 'hFFE, 0);
      check("branch_neg", 32'(pc), 'h00F);
      // Nested call/return
      step(0, 0, 2, 0, 'h100);
      step(0, 0, 3, 0, 'h200);
      check("nest_call1", 32'(pc), 'h200);
      step(0, 0, 3, 0, 'h300);
      check("nest_cnt2", 32'(ras_count), 2);
      step(0, 0, 4, 0, 0);
      check("nest_ret1", 32'(pc), 'h201);
      step(0, 0, 4, 0, 0);
      check("nest_ret2", 32'(pc), 'h101);
      // Overflow then underflow
      for (int i = 1; i <= 5; i++) begin
         step(0, 0, 2, 0, i * 'h10);
         step(0, 0, 3, 0, (i + 1) * 'h10);
      end
      check("ovf_pulse", 32'(ras_ovf), 1);
      step(0, 0, 4, 0, 0);
      check("ovf_ret1", 32'(pc), 'h51);
      check("ovf_cleared", 32'(ras_ovf), 0);
      for (int i = 0; i < 3; i++) step(0, 0, 4, 0, 0);
      check("ovf_ret4", 32'(pc), 'h21);
      step(0, 0, 4, 0, 0);
      check("unf_pulse", 32'(ras_unf), 1);
      check("unf_pc", 32'(pc), 'h22);
      // Stall holds everything
      step(0, 0, 3, 0, 'h400);
      for (int i = 0; i < 3; i++) step(0, 1, 2, 0, 'h7AA);
      check("stall_pc", 32'(pc), 'h400);
      step(0, 0, 2, 0, 'h7AA);
      check("stall_release", 32'(pc), 'h7AA);
      // Reset mid-call
      step(0, 0, 3, 0, 'h500);
      check("pre_reset_cnt", 32'(ras_count), 2);
      step(1, 0, 3, 0, 'h600);
      check("reset_mid_pc", 32'(pc), 0);
      check("reset_mid_cnt", 32'(ras_count), 0);
      // Randomized mix
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(63) == 0), ($urandom_range(7) == 0), $urandom_range(7),
              $urandom_range(4095), $urandom_range(4095));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit; successor to the fixed 12-bit +1/+N incrementers.
- Holds the architectural PC register and selects the next PC: sequential, PC-relative branch, absolute jump, call, or return.
- Contains a DEPTH-entry return-address stack (RAS) for call/return.
- Sits at the fetch stage; `pc` drives imem address; control decode drives `op`.

Parameters:
- ADDR_W, 12, PC/address width in bits.
- DEPTH, 4, RAS entries (>=2, power of two).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC and RAS this cycle, op ignored
- op  input  3  next-PC operation (encoding in package)
- offset  input  ADDR_W  two's-complement branch offset
- target  input  ADDR_W  absolute jump/call target
- pc  output  ADDR_W  current PC (registered)
- pc_plus1  output  ADDR_W  pc+1 mod 2^ADDR_W (combinational from pc)
- ras_count  output  $clog2(DEPTH)+1  valid RAS entries
- ras_empty  output  1  ras_count==0
- ras_full  output  1  ras_count==DEPTH
- ras_ovf  output  1  one-cycle pulse: call pushed while full
- ras_unf  output  1  one-cycle pulse: return popped while empty

Behaviour:
- Reset (sync, highest priority):
  - pc<=RESET_PC, ras_count<=0, RAS pointer<=0, ras_ovf<=0, ras_unf<=0.
  - RAS storage contents undefined.
  - Reset mid-call/return discards the operation.
- All next-PC results take effect at the next rising edge (latency 1); pc_plus1 follows pc combinationally.
- Arithmetic:
  - All sums are modulo 2^ADDR_W; wrap-around is silent and not an error.
  - offset is sign-interpreted.
- Priority: reset > stall > op. When stall=1, pc, RAS and counters hold; ras_ovf/ras_unf are 0 that cycle.
- op semantics (stall=0):
  - OP_SEQ: pc<=pc+1.
  - OP_BRANCH: pc<=pc+1+offset.
  - OP_JUMP: pc<=target.
  - OP_CALL:
    - pc<=target; push pc+1.
    - If not full, ras_count+1.
    - If full, the push overwrites the oldest entry (circular), ras_count stays DEPTH, ras_ovf=1 for the next cycle.
  - OP_RET:
    - If not empty, pc<=top entry and ras_count-1.
    - If empty, pc<=pc+1, RAS unchanged, ras_unf=1 for the next cycle.
  - Codes 5-7 are reserved: behave as OP_SEQ.
- RAS:
  - Circular buffer with a top pointer.
  - Push writes at ptr+1 and advances ptr.
  - Pop reads at ptr and retreats ptr (mod DEPTH).
  - A call followed immediately by a ret returns the just-pushed address (no bypass hazard, since both are registered).
- ras_ovf/ras_unf are registered pulses, cleared every cycle they are not re-triggered.
- No X on any output after the first reset edge.

Decomposition:
- Package pc_seq_pkg:
  - op encoding constants OP_SEQ=0, OP_BRANCH=1, OP_JUMP=2, OP_CALL=3, OP_RET=4.
  - Width helper for ras_count.
- Sub-module pc_adder:
  - Parametrised ADDR_W combinational a+b+cin, carry-out discarded.
  - Generalises the old plus1/plusN.
  - Instantiated twice: pc+1, and pc+1+offset.
- RAS storage stays inline.

Test Plan:
- Reset then 3 cycles OP_SEQ, RESET_PC=0 -> pc = 0,1,2,3; ras_empty=1, ras_count=0.
- Wrap: reach pc=0xFFF, OP_SEQ -> pc=0x000, no flag. Then OP_BRANCH offset=0xFFE (-2) at pc=0x010 -> pc=0x00F.
- Nest: at pc=0x100 OP_CALL target=0x200; at 0x200 OP_CALL target=0x300; OP_RET; OP_RET -> pc sequence 0x200, 0x300, 0x201, 0x101; ras_count 1, 2, 1, 0.
- Overflow, DEPTH=4: 5 consecutive calls from pc=0x10, 0x20, 0x30, 0x40, 0x50 -> ras_ovf pulses once after the 5th. Then 5 rets -> returns 0x51, 0x41, 0x31, 0x21, then ras_unf=1 with pc advancing +1.
- Stall: stall=1 for 3 cycles with op=OP_JUMP target=0x7AA -> pc and ras_count unchanged. Deassert -> pc=0x7AA the next cycle.
- Reset mid-op: assert reset in the same cycle as OP_CALL with ras_count=2 -> pc=RESET_PC, ras_count=0, no ras_ovf.
